pattern_sched: RTL and testbench
================================

PATTERN_SCHED -- requirements
Module: pattern_sched

Interface
REQ-001 SHALL have parameter H_ADDR, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ADDR, default 480, active lines per frame.
REQ-003 SHALL have parameter NUM_PAT, default 5, number of valid patterns, range 2..8.
REQ-004 SHALL have parameter FRAMES_PER_PAT, default 60, frames each pattern is shown in auto mode, range 1..1023.
REQ-005 SHALL have port pclk, input, 1, pixel clock; the only clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port de, input, 1, active-video enable from the timing generator.
REQ-008 SHALL have port X, input, 10, current pixel column.
REQ-009 SHALL have port Y, input, 10, current pixel row.
REQ-010 SHALL have port cmd_valid, input, 1, host command request.
REQ-011 SHALL have port cmd_mode, input, 1, command mode: 0 = auto, 1 = manual.
REQ-012 SHALL have port cmd_pat, input, 3, pattern index used in manual mode.
REQ-013 SHALL have port cmd_ready, output, 1, scheduler can accept a command.
REQ-014 SHALL have port cmd_err, output, 1, one-cycle pulse when a command is rejected.
REQ-015 SHALL have port pat_sel, output, 3, pattern index driven to the pattern generator.
REQ-016 SHALL have port pat_update, output, 1, one-cycle pulse in the cycle pat_sel changes value.
REQ-017 SHALL have port frame_cnt, output, 10, frames shown of the current pattern.

Function
REQ-018 SHALL detect frame start (fs) as the first pclk cycle where de=1, X=0 and Y=0; fs SHALL pulse at most once per frame, and a held or repeated (0,0) SHALL NOT re-trigger it until de has been low.
REQ-019 SHALL implement states WAIT_FS, AUTO, MANUAL and PEND.
REQ-020 WAIT_FS: exited to AUTO on the first fs after reset; pat_sel and frame_cnt do not change in this state.
REQ-021 AUTO: on each fs, frame_cnt increments; when frame_cnt = FRAMES_PER_PAT-1 at fs, frame_cnt returns to 0, pat_sel advances by 1 and pat_update pulses.
REQ-022 AUTO wrap: pat_sel = NUM_PAT-1 advances to 0.
REQ-023 MANUAL: pat_sel is held; frame_cnt increments on each fs, saturates at 1023 and does not wrap.
REQ-024 Handshake: a command is accepted in a cycle where cmd_valid=1 and cmd_ready=1; cmd_mode and cmd_pat are captured in that cycle.
REQ-025 cmd_ready SHALL be 1 in AUTO and MANUAL, and 0 in WAIT_FS and PEND.
REQ-026 A manual command with cmd_pat >= NUM_PAT SHALL be rejected: cmd_err pulses in the cycle after acceptance and the state is unchanged.
REQ-027 A valid accepted command SHALL move the state to PEND; at the next fs the captured values are applied and PEND exits.
REQ-028 Applying a manual command: pat_sel = cmd_pat, frame_cnt = 0, state goes to MANUAL.
REQ-029 Applying an auto command: pat_sel unchanged, frame_cnt = 0, state goes to AUTO.
REQ-030 pat_update SHALL pulse on apply only if the pat_sel value actually changes.
REQ-031 pat_sel SHALL change only in a fs cycle, so a frame is never split between patterns.
REQ-032 fs coinciding with command acceptance: the fs is processed by the current state first; the command is applied at the following fs.
REQ-033 All outputs SHALL be registered, with a 1-cycle latency from fs to the pat_sel/pat_update change.

Reset
REQ-034 Asserting rst_n low SHALL immediately force state = WAIT_FS, pat_sel = 0, frame_cnt = 0, pat_update = 0, cmd_err = 0, cmd_ready = 0, clearing any pending command and the fs edge tracker.
REQ-035 Reset deassertion mid-frame SHALL NOT produce fs until the next true (0,0) with de=1 that follows de low.

Verification
REQ-036 FRAMES_PER_PAT=2, 11 frames, no commands -> pat_sel sequence 0,0,1,1,2,2,3,3,4,4,0 across frames, with pat_update pulses at fs 2, 4, 6, 8 and 10.
REQ-037 Mid-frame cmd_valid with mode=1, pat=3 -> cmd_ready goes 0 next cycle, pat_sel stays unchanged until the next fs, then becomes 3 with frame_cnt=0 and a single pat_update pulse.
REQ-038 Manual command with cmd_pat=6 and NUM_PAT=5 -> cmd_err pulses for one cycle, cmd_ready stays 1, and pat_sel and state are unchanged.
REQ-039 In MANUAL, more than 1023 frames -> frame_cnt holds at 1023; then an auto command -> at the next fs frame_cnt=0 and auto advance resumes after FRAMES_PER_PAT frames.
REQ-040 rst_n pulsed low while in PEND with pat=2 -> all outputs return to reset values, and the following fs enters AUTO with pat_sel=0.
REQ-041 cmd_valid and fs in the same cycle, with AUTO at frame_cnt = FRAMES_PER_PAT-1 -> the auto advance happens at this fs and the command is applied at the next fs.

Source files
------------

// File: rtl/pattern_sched.sv
// Test-pattern scheduler: cycles patterns automatically every FRAMES_PER_PAT frames
// or holds a host-selected pattern, switching only at frame start.
module pattern_sched #(
    parameter int H_ADDR         = 640,
    parameter int V_ADDR         = 480,
    parameter int NUM_PAT        = 5,
    parameter int FRAMES_PER_PAT = 60
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       cmd_valid,
    input  logic       cmd_mode,
    input  logic [2:0] cmd_pat,
    output logic       cmd_ready,
    output logic       cmd_err,
    output logic [2:0] pat_sel,
    output logic       pat_update,
    output logic [9:0] frame_cnt
);

    typedef enum logic [1:0] {WAIT_FS, AUTO, MANUAL, PEND} state_t;

    localparam logic [9:0] CNT_LAST  = 10'(FRAMES_PER_PAT - 1);
    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [2:0] PAT_LAST  = 3'(NUM_PAT - 1);
    localparam logic [3:0] PAT_LIMIT = 4'(NUM_PAT);

    state_t     state;
    state_t     state_next;
    logic       armed;
    logic       active;
    logic       fs;
    logic       accept;
    logic       bad_cmd;
    logic       cmd_ok;
    logic       pend_mode;
    logic [2:0] pend_pat;
    logic [2:0] pat_d;
    logic [9:0] cnt_d;
    logic       upd_d;
    logic       err_d;
    logic       ready_d;

    // de reported outside the active window is not treated as active video.
    assign active  = de && (int'(X) < H_ADDR) && (int'(Y) < V_ADDR);
    assign fs      = armed && active && (X == 10'd0) && (Y == 10'd0);
    assign accept  = cmd_valid && cmd_ready;
    assign bad_cmd = cmd_mode && ({1'b0, cmd_pat} >= PAT_LIMIT);
    assign cmd_ok  = accept && !bad_cmd;

    // Frame-start tracker: re-armed only by de low, so a held (0,0) fires once.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (!de) begin
            armed <= 1'b1;
        end else if (fs) begin
            armed <= 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mode <= 1'b0;
            pend_pat  <= 3'd0;
        end else if (cmd_ok) begin
            pend_mode <= cmd_mode;
            pend_pat  <= cmd_pat;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_FS;
        end else begin
            state <= state_next;
        end
    end

    // An fs arriving with a command is consumed by the current state first.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_FS:      if (fs) state_next = AUTO;
            AUTO, MANUAL: if (cmd_ok) state_next = PEND;
            PEND:         if (fs) state_next = pend_mode ? MANUAL : AUTO;
            default:      state_next = WAIT_FS;
        endcase
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        pat_d   = pat_sel;
        cnt_d   = frame_cnt;
        upd_d   = 1'b0;
        err_d   = accept && bad_cmd;
        ready_d = (state_next == AUTO) || (state_next == MANUAL);
        if (fs) begin
            case (state)
                AUTO: begin
                    if (frame_cnt == CNT_LAST) begin
                        cnt_d = 10'd0;
                        pat_d = (pat_sel == PAT_LAST) ? 3'd0 : pat_sel + 3'd1;
                        upd_d = 1'b1;
                    end else begin
                        cnt_d = frame_cnt + 10'd1;
                    end
                end
                MANUAL: begin
                    if (frame_cnt != CNT_MAX) cnt_d = frame_cnt + 10'd1;
                end
                PEND: begin
                    cnt_d = 10'd0;
                    if (pend_mode) begin
                        pat_d = pend_pat;
                        upd_d = (pend_pat != pat_sel);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pat_sel    <= 3'd0;
            frame_cnt  <= 10'd0;
            pat_update <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            pat_sel    <= pat_d;
            frame_cnt  <= cnt_d;
            pat_update <= upd_d;
            cmd_err    <= err_d;
            cmd_ready  <= ready_d;
        end
    end

endmodule

// File: tb/tb_pattern_sched.sv
// Scoreboard bench for pattern_sched: a frame-level reference model pushes expected
// events into queues, and a negedge monitor pops and compares them.
module tb_pattern_sched;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int NP  = 5;
    localparam int FPP = 2;

    logic       pclk      = 1'b0;
    logic       rst_n     = 1'b0;
    logic       de        = 1'b0;
    logic [9:0] X         = 10'd0;
    logic [9:0] Y         = 10'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_mode  = 1'b0;
    logic [2:0] cmd_pat   = 3'd0;
    logic       cmd_ready;
    logic       cmd_err;
    logic [2:0] pat_sel;
    logic       pat_update;
    logic [9:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {int cyc; int pat; int cnt; bit ready;} stat_t;
    typedef struct {int cyc; int pat; int cnt;} upd_t;

    stat_t st_q[$];
    upd_t  upd_q[$];
    int    err_q[$];

    // Reference model: frame-level view of the scheduler.
    bit m_armed, m_started, m_manual, m_pending, m_pmode, m_ready;
    int m_ppat, m_pat, m_cnt;

    // Per-frame stimulus bookkeeping.
    int fr_k, fr_pos, fr_cp, fr_pat0, fr_cnt0, fr_rdy, fr_err;
    bit fr_cm;

    pattern_sched #(
        .H_ADDR(H), .V_ADDR(V), .NUM_PAT(NP), .FRAMES_PER_PAT(FPP)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .de(de), .X(X), .Y(Y),
        .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_pat(cmd_pat),
        .cmd_ready(cmd_ready), .cmd_err(cmd_err), .pat_sel(pat_sel),
        .pat_update(pat_update), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_started = 0; m_manual = 0; m_pending = 0;
        m_pmode = 0; m_ready = 0; m_ppat = 0; m_pat = 0; m_cnt = 0;
        st_q.delete(); upd_q.delete(); err_q.delete();
    endtask

    // Called with the inputs that the DUT will sample at the next edge.
    task automatic model_step();
        bit fs, acc, bad, upd;
        fs  = m_armed && de && (X == 10'd0) && (Y == 10'd0);
        acc = cmd_valid && m_ready;
        bad = cmd_mode && (int'(cmd_pat) >= NP);
        upd = 0;
        if (!de) m_armed = 1;
        else if (fs) m_armed = 0;
        if (fs) begin
            if (!m_started) begin
                m_started = 1;
            end else if (m_pending) begin
                m_pending = 0;
                m_cnt     = 0;
                m_manual  = m_pmode;
                if (m_pmode) begin
                    upd   = (m_ppat != m_pat);
                    m_pat = m_ppat;
                end
            end else if (m_manual) begin
                m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
            end else begin
                m_cnt++;
                if (m_cnt == FPP) begin
                    m_cnt = 0;
                    m_pat = (m_pat + 1) % NP;
                    upd   = 1;
                end
            end
        end
        if (acc && !bad) begin
            m_pending = 1;
            m_pmode   = cmd_mode;
            m_ppat    = int'(cmd_pat);
        end
        if (acc && bad) err_q.push_back(cyc + 1);
        if (upd) upd_q.push_back('{cyc + 1, m_pat, m_cnt});
        m_ready = m_started && !m_pending;
        if (fs || acc) st_q.push_back('{cyc + 1, m_pat, m_cnt, m_ready});
    endtask

    task automatic drive(input bit d, input int x, input int y,
                         input bit cv, input bit cm, input int cp);
        de        = d;
        X         = 10'(x);
        Y         = 10'(y);
        cmd_valid = cv;
        cmd_mode  = cm;
        cmd_pat   = 3'(cp);
        if (rst_n) model_step();
        @(posedge pclk);
        #1;
    endtask

    task automatic frame_px(input bit d, input int x, input int y);
        drive(d, x, y, fr_k == fr_pos, fr_cm, fr_cp);
        if (fr_k == 0) begin
            fr_pat0 = int'(pat_sel);
            fr_cnt0 = int'(frame_cnt);
        end
        if (fr_k == fr_pos) begin
            fr_rdy = int'(cmd_ready);
            fr_err = int'(cmd_err);
        end
        fr_k++;
    endtask

    // One frame: V lines of H pixels, 2 blank cycles per line, 2 more at frame end.
    task automatic run_frame(input int pos, input bit cm, input int cp, input bit dbl);
        fr_k = 0; fr_pos = pos; fr_cm = cm; fr_cp = cp;
        fr_pat0 = -1; fr_cnt0 = -1; fr_rdy = -1; fr_err = -1;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                frame_px(1'b1, x, y);
                if (dbl && x == 0 && y == 0) frame_px(1'b1, 0, 0);
            end
            frame_px(1'b0, H, y);
            frame_px(1'b0, H, y);
        end
        frame_px(1'b0, H, V);
        frame_px(1'b0, H, V);
    endtask

    task automatic do_reset_pulse(input int cycles_low);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pat_sel", int'(pat_sel), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_pat_update", int'(pat_update), 0);
        check("rst_cmd_err", int'(cmd_err), 0);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        repeat (cycles_low) @(posedge pclk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: consumes expected events when the DUT presents them.
    logic [2:0] prev_pat = 3'd0;
    always @(negedge pclk) begin
        upd_t  u;
        stat_t s;
        int    e;
        if (!rst_n) begin
            prev_pat = pat_sel;
        end else begin
            while (upd_q.size() > 0 && upd_q[0].cyc < cyc) begin
                u = upd_q.pop_front();
                check("pat_update_missing", 0, 1);
            end
            while (err_q.size() > 0 && err_q[0] < cyc) begin
                e = err_q.pop_front();
                check("cmd_err_missing", 0, 1);
            end
            if (pat_update) begin
                if (upd_q.size() == 0 || upd_q[0].cyc != cyc) begin
                    check("pat_update_unexpected", 1, 0);
                end else begin
                    u = upd_q.pop_front();
                    check("upd_pat_sel", int'(pat_sel), u.pat);
                    check("upd_frame_cnt", int'(frame_cnt), u.cnt);
                end
            end
            if (cmd_err) begin
                if (err_q.size() == 0 || err_q[0] != cyc) begin
                    check("cmd_err_unexpected", 1, 0);
                end else begin
                    e = err_q.pop_front();
                    check("cmd_err_pulse", int'(cmd_err), 1);
                end
            end
            if (pat_sel != prev_pat && !pat_update)
                check("pat_change_without_update", int'(pat_sel), int'(prev_pat));
            prev_pat = pat_sel;
            while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
                s = st_q.pop_front();
                check("stat_pat_sel", int'(pat_sel), s.pat);
                check("stat_frame_cnt", int'(frame_cnt), s.cnt);
                check("stat_cmd_ready", int'(cmd_ready), int'(s.ready));
            end
        end
    end

    initial begin
        int seq[11];
        seq = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
        model_reset();
        @(posedge pclk);
        #1;
        do_reset_pulse(3);

        // Reset released with de high at (0,0): no frame start yet.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0);
        drive(1'b1, 1, 0, 1'b1, 1'b1, 3);
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0);
        check("wait_fs_ready", int'(cmd_ready), 0);
        check("wait_fs_cnt", int'(frame_cnt), 0);
        drive(1'b0, H, 0, 1'b0, 1'b0, 0);
        drive(1'b0, H, 0, 1'b0, 1'b0, 0);

        // Auto sequence across 11 frames.
        for (int i = 0; i < 11; i++) begin
            run_frame(-1, 1'b0, 0, 1'b0);
            check($sformatf("auto_seq_%0d", i), fr_pat0, seq[i]);
        end
        check("auto_ready", int'(cmd_ready), 1);

        // Mid-frame manual command, applied at the next frame start.
        run_frame(5, 1'b1, 3, 1'b0);
        check("pend_ready_drop", fr_rdy, 0);
        check("pend_pat_hold", int'(pat_sel), 0);
        run_frame(-1, 1'b0, 0, 1'b0);
        check("manual_apply_pat", fr_pat0, 3);
        check("manual_apply_cnt", fr_cnt0, 0);

        // Out-of-range manual pattern is rejected.
        run_frame(6, 1'b1, 6, 1'b0);
        check("reject_err", fr_err, 1);
        check("reject_ready", fr_rdy, 1);
        check("reject_pat", int'(pat_sel), 3);

        // Manual frame counter saturation, then return to auto.
        repeat (1030) run_frame(-1, 1'b0, 0, 1'b0);
        check("manual_saturate", int'(frame_cnt), 1023);
        run_frame(3, 1'b0, 0, 1'b0);
        run_frame(-1, 1'b0, 0, 1'b0);
        check("auto_apply_pat", fr_pat0, 3);
        check("auto_apply_cnt", fr_cnt0, 0);
        run_frame(-1, 1'b0, 0, 1'b0);
        check("auto_resume_hold", fr_pat0, 3);
        run_frame(-1, 1'b0, 0, 1'b0);
        check("auto_resume_adv", fr_pat0, 4);

        // Command in the same cycle as an advancing frame start.
        run_frame(-1, 1'b0, 0, 1'b0);
        check("coincide_pre_cnt", fr_cnt0, FPP - 1);
        run_frame(0, 1'b1, 2, 1'b0);
        check("coincide_adv_wrap", fr_pat0, 0);
        check("coincide_ready", fr_rdy, 0);
        run_frame(-1, 1'b0, 0, 1'b0);
        check("coincide_apply", fr_pat0, 2);

        // Reset while a manual command to pattern 2 is pending.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0);
        drive(1'b1, 1, 0, 1'b1, 1'b1, 2);
        drive(1'b1, 2, 0, 1'b0, 1'b0, 0);
        check("pend_before_rst", int'(cmd_ready), 0);
        do_reset_pulse(2);
        drive(1'b1, 3, 0, 1'b0, 1'b0, 0);
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0);
        drive(1'b0, H, 0, 1'b0, 1'b0, 0);
        drive(1'b0, H, 0, 1'b0, 1'b0, 0);
        check("post_rst_no_fs", int'(cmd_ready), 0);
        run_frame(-1, 1'b0, 0, 1'b0);
        check("post_rst_pat", fr_pat0, 0);
        check("post_rst_ready", int'(cmd_ready), 1);

        // Randomized commands and held frame-start pixels.
        for (int i = 0; i < 300; i++) begin
            int pos;
            pos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : -1;
            run_frame(pos, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
        end

        drive(1'b0, H, V, 1'b0, 1'b0, 0);
        drive(1'b0, H, V, 1'b0, 1'b0, 0);
        drive(1'b0, H, V, 1'b0, 1'b0, 0);
        check("drain_upd_q", upd_q.size(), 0);
        check("drain_err_q", err_q.size(), 0);
        check("drain_st_q", st_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
